// File: rtl/pkt_pad_seq_if.sv
// Handshake bundle for the padding sequencer: message words in, padded block words out.
// The master side drives the message stream and the downstream ready; the slave is the sequencer.
interface pkt_pad_seq_if #(
  parameter int W = 64
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_blk_end;
  logic         out_last;
  logic         pad_pkt;
  logic         zero_pkt;
  logic         mgln_pkt;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_blk_end, out_last, pad_pkt, zero_pkt, mgln_pkt
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_blk_end, out_last, pad_pkt, zero_pkt, mgln_pkt
  );
endinterface

// File: rtl/pkt_pad_seq.sv
// Padding sequencer: forwards message words in BLK_WORDS-word blocks and appends
// the pad word, zero fill and bit-length word that close the final block.
module pkt_pad_seq #(
  parameter int W         = 64,
  parameter int BLK_WORDS = 16
) (
  input logic          clk,
  input logic          rst_n,
  pkt_pad_seq_if.slave bus
);
  localparam int IDX_W = $clog2(BLK_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(BLK_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_PRE_LAST = IDX_W'(BLK_WORDS - 2);
  localparam logic [W-1:0]     PAD_WORD     = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]     WORD_BITS    = W'(W);

  typedef enum logic [1:0] {
    S_DATA,
    S_PAD,
    S_ZERO,
    S_LEN
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]   len_cnt;
  logic           ld;
  logic           accept;
  logic           load_en;
  logic [W-1:0]   load_data;
  logic           load_pad;
  logic           load_zero;
  logic           load_len;

  // The output register may take a new word whenever it is empty or being drained.
  assign ld     = !bus.out_valid | bus.out_ready;
  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_DATA;
    end else begin
      state <= state_nxt;
    end
  end

  // The length word must land on the last slot of a block, so the zero fill stops
  // one slot early; a pad landing on the last slot pushes the fill into a fresh block.
  always_comb begin
    state_nxt = state;
    case (state)
      S_DATA: if (accept && bus.in_last) state_nxt = S_PAD;
      S_PAD:  if (ld) state_nxt = (idx == IDX_PRE_LAST) ? S_LEN : S_ZERO;
      S_ZERO: if (ld && (idx == IDX_PRE_LAST)) state_nxt = S_LEN;
      S_LEN:  if (ld) state_nxt = S_DATA;
      default: state_nxt = S_DATA;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    load_en      = 1'b0;
    load_data    = '0;
    load_pad     = 1'b0;
    load_zero    = 1'b0;
    load_len     = 1'b0;
    case (state)
      S_DATA: begin
        bus.in_ready = ld;
        load_en      = bus.in_valid & ld;
        load_data    = bus.in_data;
      end
      S_PAD: begin
        load_en   = ld;
        load_data = PAD_WORD;
        load_pad  = 1'b1;
      end
      S_ZERO: begin
        load_en   = ld;
        load_zero = 1'b1;
      end
      S_LEN: begin
        load_en   = ld;
        load_data = len_cnt;
        load_len  = 1'b1;
      end
      default: begin
        load_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      len_cnt <= '0;
    end else begin
      if (load_en) begin
        idx <= load_len ? '0 : idx + 1'b1;
      end
      if (load_en && load_len) begin
        len_cnt <= '0;
      end else if (accept) begin
        len_cnt <= len_cnt + WORD_BITS;
      end
    end
  end

  // Flags are cleared together with out_valid so an empty register never shows a tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data    <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_blk_end <= 1'b0;
      bus.out_last    <= 1'b0;
      bus.pad_pkt     <= 1'b0;
      bus.zero_pkt    <= 1'b0;
      bus.mgln_pkt    <= 1'b0;
    end else if (load_en) begin
      bus.out_data    <= load_data;
      bus.out_valid   <= 1'b1;
      bus.out_blk_end <= (idx == IDX_LAST);
      bus.out_last    <= load_len;
      bus.pad_pkt     <= load_pad;
      bus.zero_pkt    <= load_zero;
      bus.mgln_pkt    <= load_len;
    end else if (bus.out_ready) begin
      bus.out_valid   <= 1'b0;
      bus.out_blk_end <= 1'b0;
      bus.out_last    <= 1'b0;
      bus.pad_pkt     <= 1'b0;
      bus.zero_pkt    <= 1'b0;
      bus.mgln_pkt    <= 1'b0;
    end
  end
endmodule
